// File: rtl/switch_pio_debounced.sv
// rtl/switch_pio_debounced.sv - debounced switch PIO with edge capture and level interrupt
// Raw inputs pass through a synchroniser and per-bit debouncer before reaching the register map.
module switch_pio_debounced #(
    parameter int DATA_WIDTH      = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_out;
    logic [DATA_WIDTH-1:0] stable_q, stable_d, stable_dly_q, edge_det;
    logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d, edgecap_q, edgecap_d, clear_mask;
    logic [31:0]           readdata_d;
    logic                  wr_en;
    logic                  unused_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable_d = sync_out;
        end else begin : g_debounce
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            logic [CNT_W-1:0] cnt_q [DATA_WIDTH];
            logic [CNT_W-1:0] cnt_d [DATA_WIDTH];

            // A bit is accepted only after disagreeing with stable for DEBOUNCE_CYCLES edges in a row.
            always_comb begin
                stable_d = stable_q;
                for (int b = 0; b < DATA_WIDTH; b++) begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                    if (sync_out[b] == stable_q[b]) begin
                        cnt_d[b] = '0;
                    end else if (cnt_q[b] == CNT_LAST) begin
                        stable_d[b] = sync_out[b];
                        cnt_d[b]    = '0;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int b = 0; b < DATA_WIDTH; b++) cnt_q[b] <= '0;
                end else begin
                    for (int b = 0; b < DATA_WIDTH; b++) cnt_q[b] <= cnt_d[b];
                end
            end
        end
    endgenerate

    always_comb begin
        case (EDGE_MODE)
            1:       edge_det = ~stable_q & stable_dly_q;
            2:       edge_det = stable_q ^ stable_dly_q;
            default: edge_det = stable_q & ~stable_dly_q;
        endcase
    end

    assign wr_en = chipselect && !write_n;

    always_comb begin
        irqmask_d  = irqmask_q;
        clear_mask = '0;
        readdata_d = '0;
        if (wr_en && address == 2'd1) irqmask_d = writedata[DATA_WIDTH-1:0];
        if (wr_en && address == 2'd3) clear_mask = writedata[DATA_WIDTH-1:0];
        // New edges take priority over a simultaneous clear.
        edgecap_d = (edgecap_q & ~clear_mask) | edge_det;
        case (address)
            2'd0:    readdata_d = 32'(stable_q);
            2'd1:    readdata_d = 32'(irqmask_q);
            2'd3:    readdata_d = 32'(edgecap_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            irqmask_q    <= '0;
            edgecap_q    <= '0;
            readdata     <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            irqmask_q    <= irqmask_d;
            edgecap_q    <= edgecap_d;
            readdata     <= readdata_d;
        end
    end

    assign irq       = |(edgecap_q & irqmask_q);
    assign unused_ok = &{1'b0, writedata};

endmodule

// File: tb/tb_switch_pio_debounced.sv
// tb/tb_switch_pio_debounced.sv - directed and randomized checks against a windowed debounce model
module tb_switch_pio_debounced;
    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b1;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = 32'd0;
    logic [W-1:0]  in_port    = '0;
    logic [31:0]   rd0, rd2;
    logic          irq0, irq2;
    int            checks     = 0;
    int            failures   = 0;

    logic [W-1:0]  synq[$];
    logic [W-1:0]  win[$];
    logic [W-1:0]  m_stable, m_dly, m_mask, m_ec0, m_ec2;
    logic [31:0]   m_rd0, m_rd2;

    always #5 clk = ~clk;

    switch_pio_debounced #(.DATA_WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0)
    );

    switch_pio_debounced #(.DATA_WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [W-1:0]  s, n_stable, n_mask, n_ec0, n_ec2, clr;
        logic [31:0]   n_rd0, n_rd2;
        logic          wr;
        bit            flip;
        s = synq.pop_front();
        synq.push_back(in_port);
        win.push_back(s);
        if (win.size() > D) void'(win.pop_front());
        n_stable = m_stable;
        if (win.size() == D) begin
            for (int b = 0; b < W; b++) begin
                flip = 1'b1;
                foreach (win[i]) if (win[i][b] == m_stable[b]) flip = 1'b0;
                if (flip) n_stable[b] = ~m_stable[b];
            end
        end
        wr     = chipselect && !write_n;
        clr    = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        n_mask = (wr && address == 2'd1) ? writedata[W-1:0] : m_mask;
        n_ec0  = (m_ec0 & ~clr) | (m_stable & ~m_dly);
        n_ec2  = (m_ec2 & ~clr) | (m_stable ^ m_dly);
        case (address)
            2'd0:    begin n_rd0 = {24'd0, m_stable}; n_rd2 = {24'd0, m_stable}; end
            2'd1:    begin n_rd0 = {24'd0, m_mask};   n_rd2 = {24'd0, m_mask};   end
            2'd3:    begin n_rd0 = {24'd0, m_ec0};    n_rd2 = {24'd0, m_ec2};    end
            default: begin n_rd0 = 32'd0;             n_rd2 = 32'd0;             end
        endcase
        @(posedge clk);
        #1;
        m_dly    = m_stable;
        m_stable = n_stable;
        m_mask   = n_mask;
        m_ec0    = n_ec0;
        m_ec2    = n_ec2;
        m_rd0    = n_rd0;
        m_rd2    = n_rd2;
        check("rd_mode0", rd0, m_rd0);
        check("irq_mode0", {31'd0, irq0}, {31'd0, |(m_ec0 & m_mask)});
        check("rd_mode2", rd2, m_rd2);
        check("irq_mode2", {31'd0, irq2}, {31'd0, |(m_ec2 & m_mask)});
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        #1;
        synq.delete();
        win.delete();
        repeat (S) synq.push_back('0);
        m_stable = '0; m_dly = '0; m_mask = '0; m_ec0 = '0; m_ec2 = '0;
        m_rd0 = '0; m_rd2 = '0;
        check("rst_rd0", rd0, 32'd0);
        check("rst_irq0", {31'd0, irq0}, 32'd0);
        check("rst_rd2", rd2, 32'd0);
        check("rst_irq2", {31'd0, irq2}, 32'd0);
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_hold_rd0", rd0, 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    initial begin
        int hold;
        @(posedge clk);
        #1;

        // Input high through reset is learned as a rising edge after S+D+1 edges.
        in_port = 8'hFF;
        apply_reset(3);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            step();
            check("t1_rd_after_rst", rd0, 32'd0);
        end
        address = 2'd0;
        idle(2);
        check("t1_data_pre", rd0, 32'd0);
        step();
        check("t1_data", rd0, 32'h0000_00FF);
        address = 2'd3;
        step();
        check("t1_ec", rd0, 32'h0000_00FF);
        check("t1_irq", {31'd0, irq0}, 32'd0);

        // Single bit rise: DATA after edge 7, irq once masked in.
        in_port = 8'h00;
        idle(12);
        wr_reg(2'd3, 32'hFF);
        in_port = 8'h01;
        address = 2'd0;
        idle(6);
        check("t2_data_pre", rd0, 32'd0);
        step();
        check("t2_data", rd0, 32'h01);
        check("t2_irq_masked", {31'd0, irq0}, 32'd0);
        address = 2'd3;
        step();
        check("t2_ec", rd0, 32'h01);
        wr_reg(2'd1, 32'h01);
        check("t2_irq", {31'd0, irq0}, 32'd1);

        // Bounce on bit3 shorter than the debounce period is rejected.
        wr_reg(2'd3, 32'h01);
        wr_reg(2'd1, 32'hFF);
        for (int i = 0; i < 10; i++) begin
            in_port[3] = ~in_port[3];
            repeat (2) begin
                step();
                check("t3_irq", {31'd0, irq0}, 32'd0);
            end
        end
        in_port[3] = 1'b0;
        idle(8);
        address = 2'd0;
        step();
        check("t3_data", rd0, 32'h01);

        // Write-1-to-clear, and set winning over a same-cycle clear.
        in_port = 8'h00;
        idle(10);
        wr_reg(2'd3, 32'hFF);
        in_port = 8'h05;
        idle(10);
        address = 2'd3;
        step();
        check("t4_ec05", rd0, 32'h05);
        wr_reg(2'd3, 32'h04);
        address = 2'd3;
        step();
        check("t4_ec01", rd0, 32'h01);
        in_port = 8'h04;
        idle(10);
        wr_reg(2'd3, 32'hFF);
        in_port = 8'h05;
        idle(6);
        wr_reg(2'd3, 32'h01);
        address = 2'd3;
        step();
        check("t4_set_wins", rd0, 32'h01);

        // Falling edge captured in any-edge mode only.
        idle(8);
        wr_reg(2'd3, 32'hFF);
        in_port = 8'h04;
        idle(10);
        address = 2'd3;
        step();
        check("t5_mode0", rd0, 32'h00);
        check("t5_mode2", rd2, 32'h01);

        // Reset mid-debounce discards progress on bit1.
        in_port = 8'h06;
        address = 2'd0;
        idle(5);
        apply_reset(3);
        step();
        check("t6_data_zero", rd0, 32'd0);
        idle(5);
        check("t6_data_pre", rd0, 32'd0);
        step();
        check("t6_data", rd0, 32'h06);

        // Randomized traffic against the model.
        repeat (60) begin
            in_port = W'($urandom);
            hold = $urandom_range(1, 8);
            repeat (hold) begin
                address = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: begin chipselect = 1'b1; write_n = 1'b0; writedata = $urandom; end
                    1: begin chipselect = 1'b0; write_n = 1'b0; writedata = $urandom; end
                    default: begin chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; end
                endcase
                step();
            end
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
